// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_pkg;

  typedef enum logic [2:0] {
    RST   = 3'd0,
    FILL  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    CAPT  = 3'd5,
    DRAIN = 3'd6
  } seq_state_t;

  localparam int unsigned N_2_DEFAULT = 5;
  localparam int unsigned FL          = 2 ** N_2_DEFAULT;

endpackage

// File: rtl/fft_frame_buffer.sv
// Frame-sized register file: synchronous write, asynchronous read.
module fft_frame_buffer #(
  parameter int unsigned W   = 16,
  parameter int unsigned N_2 = 5
) (
  input  logic           clk,
  input  logic           we,
  input  logic [N_2-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic [N_2-1:0] raddr,
  output logic [W-1:0]   rdata_c
);

  localparam int unsigned DEPTH = 2 ** N_2;

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller around an FFT core: fill, burst load, start, capture, drain,
// with a done watchdog and core reset control.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned width   = 16,
  parameter int unsigned N_2     = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width-1:0] out_data,
  output logic               out_last,
  output logic               fft_reset,
  output logic               fft_load,
  output logic               fft_start,
  output logic [width-1:0]   fft_rd,
  input  logic [2*width-1:0] fft_wd,
  input  logic               fft_done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [N_2-1:0] CNT_MAX = '1;

  seq_state_t state, state_nxt;
  logic [N_2-1:0] cnt, cnt_nxt;
  logic [WDW-1:0] wdog, wdog_nxt;
  logic           terr_nxt;
  logic           in_we, out_we;
  logic [width-1:0]   in_rd_c;
  logic [2*width-1:0] out_rd_c;

  logic               in_ready_nxt, out_valid_nxt, out_last_nxt, fft_reset_nxt;
  logic               fft_load_nxt, fft_start_nxt, busy_nxt;
  logic [width-1:0]   fft_rd_nxt;
  logic [2*width-1:0] out_data_nxt;

  // Buffers are read at the next count so that data outputs can be registered.
  fft_frame_buffer #(.W(width), .N_2(N_2)) u_inbuf (
    .clk     (clk),
    .we      (in_we),
    .waddr   (cnt),
    .wdata   (in_data),
    .raddr   (cnt_nxt),
    .rdata_c (in_rd_c)
  );

  fft_frame_buffer #(.W(2*width), .N_2(N_2)) u_outbuf (
    .clk     (clk),
    .we      (out_we),
    .waddr   (cnt),
    .wdata   (fft_wd),
    .raddr   (cnt_nxt),
    .rdata_c (out_rd_c)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RST;
      cnt         <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      fft_reset   <= 1'b1;
      fft_load    <= 1'b0;
      fft_start   <= 1'b0;
      fft_rd      <= '0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wdog        <= wdog_nxt;
      timeout_err <= terr_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
      out_last    <= out_last_nxt;
      out_data    <= out_data_nxt;
      fft_reset   <= fft_reset_nxt;
      fft_load    <= fft_load_nxt;
      fft_start   <= fft_start_nxt;
      fft_rd      <= fft_rd_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state, counter and buffer write control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wdog_nxt  = wdog;
    terr_nxt  = timeout_err;
    in_we     = 1'b0;
    out_we    = 1'b0;
    case (state)
      RST: begin
        if (cnt == N_2'(1)) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + N_2'(1);
        end
      end
      FILL: begin
        if (in_valid && in_ready) begin
          in_we = 1'b1;
          if (cnt == CNT_MAX) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + N_2'(1);
          end
        end
      end
      LOAD: begin
        if (cnt == CNT_MAX) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + N_2'(1);
        end
      end
      START: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
        wdog_nxt  = '0;
      end
      WAIT: begin
        if (fft_done) begin
          out_we    = 1'b1;
          state_nxt = CAPT;
          cnt_nxt   = N_2'(1);
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          terr_nxt  = 1'b1;
          state_nxt = RST;
          cnt_nxt   = '0;
        end else begin
          wdog_nxt = wdog + WDW'(1);
        end
      end
      CAPT: begin
        // The core streams without stalls; a gap in done is a broken burst.
        if (fft_done) begin
          out_we = 1'b1;
          if (cnt == CNT_MAX) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + N_2'(1);
          end
        end else begin
          terr_nxt  = 1'b1;
          state_nxt = RST;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (cnt == CNT_MAX) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + N_2'(1);
          end
        end
      end
      default: begin
        state_nxt = RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the coming state, registered above.
  always_comb begin
    in_ready_nxt  = (state_nxt == FILL);
    fft_reset_nxt = (state_nxt == RST);
    fft_load_nxt  = (state_nxt == LOAD);
    fft_start_nxt = (state_nxt == START);
    out_valid_nxt = (state_nxt == DRAIN);
    out_last_nxt  = (state_nxt == DRAIN) && (cnt_nxt == CNT_MAX);
    busy_nxt      = (state_nxt != FILL);
    fft_rd_nxt    = (state_nxt == LOAD) ? in_rd_c : '0;
    out_data_nxt  = (state_nxt == DRAIN) ? out_rd_c : '0;
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a behavioural DFT core model.
module tb_fft_frame_sequencer;
  import fft_pkg::*;

  localparam real PI = 3.14159265358979;

  typedef logic signed [15:0] frame_t [FL];
  typedef logic [31:0] words_t [FL];
  typedef bit bits_t [FL];

  logic clk, reset;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data, fft_rd;
  logic [31:0] out_data, fft_wd;
  logic fft_reset, fft_load, fft_start, fft_done, busy, timeout_err;

  int checks = 0;
  int failures = 0;
  bit core_dead = 0;
  int start_cnt = 0;
  int load_run = 0;
  int last_load_run = 0;
  words_t t2_got;

  fft_frame_sequencer #(.width(16), .N_2(5), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fft_reset(fft_reset), .fft_load(fft_load), .fft_start(fft_start), .fft_rd(fft_rd),
    .fft_wd(fft_wd), .fft_done(fft_done), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rnd16(input real v);
    int r;
    r = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    return 16'(r);
  endfunction

  // Scaled DFT bin: X[k]/FL, packed {re, im}.
  function automatic logic [31:0] dft_bin(input frame_t x, input int k);
    real re, im, a;
    int xi;
    re = 0.0; im = 0.0;
    for (int n = 0; n < FL; n++) begin
      xi = x[n];
      a  = 2.0 * PI * real'(k * n) / real'(FL);
      re = re + real'(xi) * $cos(a);
      im = im - real'(xi) * $sin(a);
    end
    return {rnd16(re / real'(FL)), rnd16(im / real'(FL))};
  endfunction

  // Core model: captures the load burst, answers start after a short latency.
  initial begin
    frame_t cap;
    words_t res;
    int idx, phase, lat, bin;
    fft_done = 1'b0; fft_wd = '0; idx = 0; phase = 0; lat = 0; bin = 0;
    for (int k = 0; k < FL; k++) cap[k] = '0;
    forever begin
      @(negedge clk);
      if (fft_reset) begin
        phase = 0; idx = 0; fft_done = 1'b0; fft_wd = '0;
      end else begin
        if (fft_load) begin
          if (idx < FL) cap[idx] = fft_rd;
          idx++;
        end else idx = 0;
        case (phase)
          0: if (fft_start) begin
               for (int k = 0; k < FL; k++) res[k] = dft_bin(cap, k);
               phase = 1; lat = 0;
             end
          1: if (!core_dead) begin
               lat++;
               if (lat == 4) begin phase = 2; bin = 0; end
             end
          2: begin
               fft_done = 1'b1; fft_wd = res[bin]; bin++;
               if (bin == FL) phase = 3;
             end
          default: begin fft_done = 1'b0; fft_wd = '0; phase = 0; end
        endcase
      end
    end
  end

  // Monitor of load burst lengths and start pulse cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (fft_start) start_cnt++;
      if (fft_load) load_run++;
      else if (load_run > 0) begin last_load_run = load_run; load_run = 0; end
    end
  end

  task automatic send_frame(input frame_t s, input bit gaps);
    int i, cyc;
    bit fire;
    i = 0; cyc = 0;
    @(negedge clk);
    while (i < FL && cyc < 3000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = s[i];
      fire = in_valid && in_ready;
      @(negedge clk); cyc++;
      if (fire) i++;
    end
    in_valid = 1'b0;
    checks++;
    if (i != FL) begin failures++; $display("FAIL send_count accepted=%0d required=%0d", i, FL); end
  endtask

  task automatic collect_frame(input bit rnd, output words_t got, output bits_t lasts, output bit stable_ok);
    int n, cyc;
    bit pend;
    logic [31:0] held;
    n = 0; cyc = 0; pend = 0; held = '0; stable_ok = 1;
    for (int k = 0; k < FL; k++) begin got[k] = '0; lasts[k] = 0; end
    while (n < FL && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (pend && (!out_valid || out_data !== held)) stable_ok = 0;
      pend = 0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin got[n] = out_data; lasts[n] = out_last; n++; end
      else if (out_valid) begin pend = 1; held = out_data; end
    end
    @(negedge clk);
    out_ready = 1'b1;
    checks++;
    if (n != FL) begin failures++; $display("FAIL collect_count got=%0d required=%0d", n, FL); end
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, fft_load, fft_start, fft_reset, busy, timeout_err} !== 8'b0000_0110) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=00000110",
               {in_ready, out_valid, out_last, fft_load, fft_start, fft_reset, busy, timeout_err});
    end
    checks++;
    if (fft_rd !== 16'h0 || out_data !== 32'h0) begin
      failures++; $display("FAIL reset_data fft_rd=%h out_data=%h required=0", fft_rd, out_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fft_reset !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_cycle2 fft_reset=%b in_ready=%b required=1/0", fft_reset, in_ready);
    end
    @(negedge clk);
    checks++;
    if (fft_reset !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_cycle3 fft_reset=%b in_ready=%b busy=%b required=0/1/0", fft_reset, in_ready, busy);
    end
  endtask

  task automatic run_and_check(input string name, input frame_t s, input bit gaps, input bit rnd);
    words_t got;
    bits_t lasts;
    bit stable;
    int s0;
    s0 = start_cnt;
    fork
      send_frame(s, gaps);
      collect_frame(rnd, got, lasts, stable);
    join
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (got[k] !== dft_bin(s, k)) begin
        failures++; $display("FAIL %s_bin%0d got=%h required=%h", name, k, got[k], dft_bin(s, k));
      end
      checks++;
      if (lasts[k] !== (k == FL - 1)) begin
        failures++; $display("FAIL %s_last%0d got=%b required=%b", name, k, lasts[k], k == FL - 1);
      end
    end
    checks++;
    if (last_load_run != FL) begin failures++; $display("FAIL %s_load_len got=%0d required=%0d", name, last_load_run, FL); end
    checks++;
    if (start_cnt - s0 != 1) begin failures++; $display("FAIL %s_start_pulses got=%0d required=1", name, start_cnt - s0); end
    checks++;
    if (!stable) begin failures++; $display("FAIL %s_stall_stable got=0 required=1", name); end
    t2_got = got;
  endtask

  function automatic frame_t ramp_frame();
    frame_t f;
    for (int n = 0; n < FL; n++) f[n] = 16'(n * 1000 - 16000);
    return f;
  endfunction

  task automatic test_stream;
    run_and_check("stream", ramp_frame(), 1'b0, 1'b0);
    checks++;
    if (t2_got[0] !== 32'hFE0C_0000) begin
      failures++; $display("FAIL stream_bin0_hand got=%h required=fe0c0000", t2_got[0]);
    end
  endtask

  task automatic test_stall;
    words_t ref_got;
    ref_got = t2_got;
    run_and_check("stall", ramp_frame(), 1'b1, 1'b1);
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (t2_got[k] !== ref_got[k]) begin
        failures++; $display("FAIL stall_vs_stream bin%0d got=%h required=%h", k, t2_got[k], ref_got[k]);
      end
    end
  endtask

  task automatic test_timeout;
    frame_t f;
    int w, first, rst_seen;
    for (int n = 0; n < FL; n++) f[n] = 16'(((n * 37) % 64) * 200 - 6000);
    core_dead = 1;
    send_frame(f, 1'b0);
    w = 0;
    while (!fft_start && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (!fft_start) begin failures++; $display("FAIL timeout_start_seen got=0 required=1"); end
    first = -1; rst_seen = 0;
    for (int s = 1; s <= 80; s++) begin
      @(negedge clk);
      if (timeout_err && first < 0) begin first = s; rst_seen = fft_reset; end
    end
    checks++;
    if (first != 65) begin failures++; $display("FAIL timeout_cycle got=%0d required=65", first); end
    checks++;
    if (rst_seen != 1) begin failures++; $display("FAIL timeout_core_reset got=%0d required=1", rst_seen); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL timeout_in_ready got=%b required=1", in_ready); end
    core_dead = 0;
    run_and_check("after_timeout", f, 1'b0, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b required=1", timeout_err); end
  endtask

  task automatic test_reset_mid_load;
    frame_t f;
    int ld, w;
    for (int n = 0; n < FL; n++) f[n] = 16'(n * 300);
    send_frame(f, 1'b0);
    ld = 0; w = 0;
    while (w < 200) begin
      if (fft_load) ld++;
      if (ld == 11) break;
      @(negedge clk); w++;
    end
    checks++;
    if (ld != 11) begin failures++; $display("FAIL midload_reach got=%0d required=11", ld); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, fft_load, fft_start, fft_reset, busy, timeout_err} !== 8'b0000_0110) begin
      failures++;
      $display("FAIL midload_reset_outputs got=%b required=00000110",
               {in_ready, out_valid, out_last, fft_load, fft_start, fft_reset, busy, timeout_err});
    end
    checks++;
    if (fft_rd !== 16'h0) begin failures++; $display("FAIL midload_fft_rd got=%h required=0", fft_rd); end
    @(negedge clk);
    reset = 1'b1;
    run_and_check("after_midload", ramp_frame(), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    frame_t f1, f2;
    words_t g1, g2;
    bits_t l1, l2;
    bit st1, st2, done6;
    int viol;
    for (int n = 0; n < FL; n++) begin f1[n] = '0; f2[n] = 16'h0400; end
    f1[0] = 16'h7FFF;
    done6 = 0; viol = 0;
    fork
      begin send_frame(f1, 1'b0); send_frame(f2, 1'b0); end
      begin collect_frame(1'b0, g1, l1, st1); collect_frame(1'b0, g2, l2, st2); done6 = 1; end
      begin
        for (int c = 0; c < 8000 && !done6; c++) begin
          @(negedge clk);
          if (busy && in_ready) viol++;
        end
      end
    join
    for (int k = 0; k < FL; k++) begin
      checks++;
      if (g1[k] !== 32'h0400_0000) begin
        failures++; $display("FAIL b2b_impulse_bin%0d got=%h required=04000000", k, g1[k]);
      end
      checks++;
      if (g2[k] !== ((k == 0) ? 32'h0400_0000 : 32'h0)) begin
        failures++; $display("FAIL b2b_dc_bin%0d got=%h required=%h", k, g2[k], (k == 0) ? 32'h0400_0000 : 32'h0);
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL b2b_in_ready_busy got=%0d required=0", viol); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
